// File: rtl/wisc_pipe_pkg.sv
// Purpose: shared encodings for the WISC-SP13 pipeline sequencing logic (forward selects, EX control FSM states).
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: FWD_* operand-select codes, ST_* FSM state codes, REG_AW_DEFAULT, satInc16 helper.
package wisc_pipe_pkg;

    localparam int REG_AW_DEFAULT = 3;

    // EX operand select encoding (RD1/RD2 mux in EX)
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file value (WB handled by RF write-before-read)
    localparam logic [1:0] FWD_MEM = 2'b01;  // EX/MEM ALUResult
    localparam logic [1:0] FWD_WB  = 2'b10;  // MEM/WB write data

    // Execute-stage sequencing FSM
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Saturating 16-bit increment used by the optional performance counters
    function automatic logic [15:0] satInc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Purpose: operand-forwarding match/priority for one EX source register.
// Latency: combinational (registered by the parent on ID->EX advance).
// Backpressure: none; pure function of the current pipeline tags.
// Ports: srcReg/srcVld = ID source specifier and use flag; exWr/exRegWrite/exMemRead = EX producer;
//        memWr/memRegWrite = MEM producer; sel = next select code; exMatch = source names the EX destination.
module fwd_sel_unit
    import wisc_pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] srcReg,
    input  logic              srcVld,
    input  logic [REG_AW-1:0] exWr,
    input  logic              exRegWrite,
    input  logic              exMemRead,
    input  logic [REG_AW-1:0] memWr,
    input  logic              memRegWrite,
    output logic [1:0]        sel,
    output logic              exMatch
);

    // Raw tag match against EX; the parent combines this with the load flags for load-use detection.
    assign exMatch = srcVld && (srcReg == exWr);

    // The EX producer is the youngest, so it wins over MEM. A load in EX has no result yet,
    // so it never forwards from EX; the parent stalls instead and the match re-resolves to WB.
    always_comb begin
        sel = FWD_RF;
        if (exMatch && exRegWrite && !exMemRead) begin
            sel = FWD_MEM;
        end else if (srcVld && memRegWrite && (srcReg == memWr)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Purpose: EX-stage sequencing: forward selects, load-use bubbles, branch flushes, halt drain, memory freeze.
// Latency: stall/bubble/flush/freeze combinational; fwd_a/fwd_b registered on ID->EX advance; halted 1+DRAIN_CYCLES unfrozen edges after halt.
// Backpressure: mem_busy freezes every register here and in the pipe; flushes wait until memory is ready.
// Ports: id_* = ID source tags; ex_*/mem_* = producer tags; br_taken/halt_ex = MEM/EX control events;
//        fwd_a/fwd_b = EX operand selects; stall/bubble/flush/freeze_all = pipe control; halted/err = status.
// Optional: define EX_HAZ_PERF_CNT_EN to add perf_stall_cnt/perf_flush_cnt saturating counters.
module ex_hazard_ctrl
    import wisc_pipe_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEFAULT,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_vld,
    input  logic [REG_AW-1:0] id_rs,
    input  logic              id_rs_vld,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rt_vld,
    input  logic [REG_AW-1:0] ex_wr,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_wr,
    input  logic              mem_regwrite,
    input  logic              br_taken,
    input  logic              halt_ex,
    input  logic              mem_busy,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic              freeze_all,
    output logic              halted,
    output logic              err
`ifdef EX_HAZ_PERF_CNT_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    logic [1:0]       state;
    logic [CNT_W-1:0] drainCnt;

    logic [1:0] selANext;
    logic [1:0] selBNext;
    logic       exMatchA;
    logic       exMatchB;
    logic       loadUse;
    logic       frozen;

    logic stallComb;
    logic bubbleComb;
    logic flushIfIdComb;
    logic flushIdExComb;
    logic flushExMemComb;

    fwd_sel_unit #(.REG_AW(REG_AW)) uFwdA (
        .srcReg      (id_rs),
        .srcVld      (id_rs_vld),
        .exWr        (ex_wr),
        .exRegWrite  (ex_regwrite),
        .exMemRead   (ex_memread),
        .memWr       (mem_wr),
        .memRegWrite (mem_regwrite),
        .sel         (selANext),
        .exMatch     (exMatchA)
    );

    fwd_sel_unit #(.REG_AW(REG_AW)) uFwdB (
        .srcReg      (id_rt),
        .srcVld      (id_rt_vld),
        .exWr        (ex_wr),
        .exRegWrite  (ex_regwrite),
        .exMemRead   (ex_memread),
        .memWr       (mem_wr),
        .memRegWrite (mem_regwrite),
        .sel         (selBNext),
        .exMatch     (exMatchB)
    );

    // Register 0 is deliberately not exempt: it can be written like any other register.
    assign loadUse = id_vld && ex_memread && ex_regwrite && (exMatchA || exMatchB);

    // HALT keeps the whole pipe frozen until reset, the same way a busy memory does.
    assign frozen = mem_busy || (state == ST_HALT);

    // Priority: frozen suppresses everything (br_taken is held in MEM and re-presented),
    // then a taken branch flushes and overrides any stall, then drain, then halt entry, then load-use.
    always_comb begin
        stallComb      = 1'b0;
        bubbleComb     = 1'b0;
        flushIfIdComb  = 1'b0;
        flushIdExComb  = 1'b0;
        flushExMemComb = 1'b0;
        if (!frozen) begin
            if (br_taken) begin
                flushIfIdComb  = 1'b1;
                flushIdExComb  = 1'b1;
                flushExMemComb = 1'b1;
            end else if (state == ST_DRAIN) begin
                stallComb     = 1'b1;
                flushIdExComb = 1'b1;
            end else if (halt_ex) begin
                // Halt entering drain: nothing younger than the halt may proceed.
                stallComb     = 1'b1;
                flushIfIdComb = 1'b1;
                flushIdExComb = 1'b1;
            end else if (loadUse) begin
                stallComb  = 1'b1;
                bubbleComb = 1'b1;
            end
        end
    end

    assign stall_if_id  = stallComb;
    assign bubble_ex    = bubbleComb;
    assign flush_if_id  = flushIfIdComb;
    assign flush_id_ex  = flushIdExComb;
    assign flush_ex_mem = flushExMemComb;
    assign freeze_all   = frozen;
    assign halted       = (state == ST_HALT);

    // Forward selects travel with the ID/EX register: a NOP entering EX (bubble or flush)
    // carries RF selects; a held ID/EX keeps its selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else if (!frozen) begin
            if (bubbleComb || flushIdExComb) begin
                fwd_a <= FWD_RF;
                fwd_b <= FWD_RF;
            end else if (!stallComb) begin
                fwd_a <= selANext;
                fwd_b <= selBNext;
            end
        end
    end

    // Halt drain sequencing. A halt paired with a taken branch is on the squashed path and ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            drainCnt <= '0;
        end else if (!frozen) begin
            case (state)
                ST_RUN: begin
                    if (halt_ex && !br_taken) begin
                        state    <= ST_DRAIN;
                        drainCnt <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    // The edge that takes the count to zero is also the edge into HALT.
                    if (drainCnt <= CNT_W'(1)) begin
                        state    <= ST_HALT;
                        drainCnt <= '0;
                    end else begin
                        drainCnt <= drainCnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Protocol errors are recorded even while frozen: a branch resolving in HALT must be caught.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((br_taken && ((state == ST_DRAIN) || (state == ST_HALT))) ||
                     (halt_ex && (state == ST_DRAIN))) begin
            err <= 1'b1;
        end
    end

`ifdef EX_HAZ_PERF_CNT_EN
    // bubble_ex marks load-use stall cycles only; flush_ex_mem marks branch flush events only.
    // Both are already zero while frozen, so frozen cycles are never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (bubbleComb) begin
                perf_stall_cnt <= satInc16(perf_stall_cnt);
            end
            if (flushExMemComb) begin
                perf_flush_cnt <= satInc16(perf_flush_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Purpose: directed self-checking bench for ex_hazard_ctrl with an expected-value scoreboard queue.
// Latency: each step drives inputs 1ns after a rising edge and samples outputs 2ns later.
// Backpressure: mem_busy is driven directly to exercise freeze behaviour.
module tb_ex_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_vld;
    logic [2:0] id_rs;
    logic       id_rs_vld;
    logic [2:0] id_rt;
    logic       id_rt_vld;
    logic [2:0] ex_wr;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [2:0] mem_wr;
    logic       mem_regwrite;
    logic       br_taken;
    logic       halt_ex;
    logic       mem_busy;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall_if_id;
    logic       bubble_ex;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       flush_ex_mem;
    logic       freeze_all;
    logic       halted;
    logic       err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [11:0] vec;
    } exp_t;

    exp_t sb[$];

    logic [11:0] obs;
    assign obs = {fwd_a, fwd_b, stall_if_id, bubble_ex, flush_if_id, flush_id_ex,
                  flush_ex_mem, freeze_all, halted, err};

    ex_hazard_ctrl #(.REG_AW(3), .DRAIN_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_vld       (id_vld),
        .id_rs        (id_rs),
        .id_rs_vld    (id_rs_vld),
        .id_rt        (id_rt),
        .id_rt_vld    (id_rt_vld),
        .ex_wr        (ex_wr),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .mem_wr       (mem_wr),
        .mem_regwrite (mem_regwrite),
        .br_taken     (br_taken),
        .halt_ex      (halt_ex),
        .mem_busy     (mem_busy),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_if_id  (stall_if_id),
        .bubble_ex    (bubble_ex),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_ex_mem (flush_ex_mem),
        .freeze_all   (freeze_all),
        .halted       (halted),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector: fa fb stall bubble flushIfId flushIdEx flushExMem freeze halted err
    function automatic logic [11:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic st, input logic bu, input logic fi,
                                       input logic fd, input logic fe, input logic fz,
                                       input logic ha, input logic er);
        return {fa, fb, st, bu, fi, fd, fe, fz, ha, er};
    endfunction

    task automatic clearIn();
        id_vld = 0; id_rs = 0; id_rs_vld = 0; id_rt = 0; id_rt_vld = 0;
        ex_wr = 0; ex_regwrite = 0; ex_memread = 0;
        mem_wr = 0; mem_regwrite = 0;
        br_taken = 0; halt_ex = 0; mem_busy = 0;
    endtask

    // Push the expectation, let combinational outputs settle, then pop and compare.
    task automatic chk(input string tag, input logic [11:0] v);
        exp_t e;
        e.tag = tag;
        e.vec = v;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        checks++;
        assert (obs === e.vec) else begin
            errors++;
            $error("FAIL %s observed=%03h expected=%03h", e.tag, obs, e.vec);
        end
    endtask

    // Check this cycle's outputs, then advance to 1ns after the next rising edge.
    task automatic cyc(input string tag, input logic [11:0] v);
        chk(tag, v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clearIn();
        @(posedge clk); #1;
        chk("reset", 12'h000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // add r3 in EX, ID reads r3 on rs
        id_vld = 1; id_rs = 3; id_rs_vld = 1; id_rt = 1; id_rt_vld = 1;
        ex_wr = 3; ex_regwrite = 1;
        cyc("exfwd_pre", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        clearIn();
        cyc("exfwd_a01", mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

        // ld r2 in EX, ID reads r2 on rt: one bubble, then WB forward
        id_vld = 1; id_rt = 2; id_rt_vld = 1;
        ex_wr = 2; ex_regwrite = 1; ex_memread = 1;
        cyc("lduse_stall", mk(2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0));
        ex_wr = 0; ex_regwrite = 0; ex_memread = 0;
        mem_wr = 2; mem_regwrite = 1;
        cyc("lduse_release", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        clearIn();
        cyc("lduse_fwdb10", mk(2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));

        // EX and MEM both write r5: youngest (EX) wins on both sources
        id_vld = 1; id_rs = 5; id_rs_vld = 1; id_rt = 5; id_rt_vld = 1;
        ex_wr = 5; ex_regwrite = 1; mem_wr = 5; mem_regwrite = 1;
        cyc("prio_pre", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        clearIn();
        cyc("prio_ex_wins", mk(2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));

        // r0 written in MEM is forwarded like any register
        id_vld = 1; id_rs = 0; id_rs_vld = 1; id_rt = 0; id_rt_vld = 0;
        mem_wr = 0; mem_regwrite = 1;
        cyc("r0_pre", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        clearIn();
        cyc("r0_fwd_wb", mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

        // taken branch during a load-use stall: flush wins over stall and bubble
        id_vld = 1; id_rs = 4; id_rs_vld = 1;
        ex_wr = 4; ex_regwrite = 1; ex_memread = 1; br_taken = 1;
        cyc("br_over_stall", mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0));
        clearIn();
        cyc("br_after", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

        // halt squashed by a taken branch stays in RUN
        halt_ex = 1; br_taken = 1;
        cyc("halt_sq_flush", mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0));
        clearIn();
        cyc("halt_sq_run", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        id_vld = 1; id_rt = 6; id_rt_vld = 1;
        ex_wr = 6; ex_regwrite = 1; ex_memread = 1;
        cyc("halt_sq_lduse", mk(2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0));
        clearIn();

        // halt drain: halted exactly 3 edges after halt_ex
        halt_ex = 1;
        cyc("halt_enter", mk(2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 0, 0));
        clearIn();
        cyc("drain_1", mk(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0));
        cyc("drain_2", mk(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0));
        br_taken = 1;
        cyc("halted_3", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0));
        clearIn();
        cyc("halt_br_err", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 1));
        cyc("halt_err_sticky", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 1));

        // asynchronous reset out of HALT
        rst_n = 1'b0;
        chk("rst_from_halt", 12'h000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // halt drain with four mem_busy cycles: halted 7 edges later; halt_ex in DRAIN sets err
        halt_ex = 1;
        cyc("bd_enter", mk(2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 0, 0));
        clearIn(); mem_busy = 1;
        cyc("bd_busy1", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0));
        cyc("bd_busy2", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0));
        mem_busy = 0; halt_ex = 1;
        cyc("bd_drain_a", mk(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0));
        halt_ex = 0; mem_busy = 1;
        cyc("bd_busy3", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1));
        cyc("bd_busy4", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1));
        mem_busy = 0;
        cyc("bd_drain_b", mk(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 1));
        cyc("bd_halted_7", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 1));

        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // reset in the middle of DRAIN returns straight to RUN
        halt_ex = 1;
        cyc("md_enter", mk(2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 0, 0));
        clearIn();
        chk("md_draining", mk(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0));
        rst_n = 1'b0;
        chk("md_rst_async", 12'h000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("md_run_idle", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        id_vld = 1; id_rs = 1; id_rs_vld = 1;
        ex_wr = 1; ex_regwrite = 1; ex_memread = 1;
        cyc("md_run_lduse", mk(2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0));
        clearIn();
        cyc("md_run_clear", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Pipeline sequencing controller for the execute stage of the 5-stage WISC-SP13 core.
- Pre-computes operand-forwarding selects for the EX ALU/BJ adder and registers them alongside ID/EX.
- Detects load-use hazards and inserts bubbles; flushes younger stages on a taken branch/jump resolved in MEM.
- Sequences halt drain to a frozen halted state, and freezes the whole pipe while data memory is busy.

Parameters:
- REG_AW, 3, register-specifier width.
- DRAIN_CYCLES, 2, cycles after halt leaves EX before `halted` asserts (MEM + WB).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_vld  in  1  valid instruction in ID.
- id_rs  in  REG_AW  ID source A (feeds RD1).
- id_rs_vld  in  1  ID uses source A.
- id_rt  in  REG_AW  ID source B (feeds RD2).
- id_rt_vld  in  1  ID uses source B.
- ex_wr  in  REG_AW  EX destination (WR_Out_ToMem).
- ex_regwrite  in  1  EX writes the register file.
- ex_memread  in  1  EX is a load.
- mem_wr  in  REG_AW  MEM destination.
- mem_regwrite  in  1  MEM writes the register file.
- br_taken  in  1  PCsel from MEM (taken branch/jump).
- halt_ex  in  1  valid halt in EX.
- mem_busy  in  1  data memory not ready this cycle.
- fwd_a  out  2  RD1 select in EX: 00 RF, 01 MEM ALUResult, 10 WB write data.
- fwd_b  out  2  RD2 select in EX, same encoding.
- stall_if_id  out  1  hold PC and IF/ID.
- bubble_ex  out  1  load NOP into ID/EX.
- flush_if_id  out  1  squash IF/ID.
- flush_id_ex  out  1  squash ID/EX.
- flush_ex_mem  out  1  squash EX/MEM.
- freeze_all  out  1  hold every pipeline register.
- halted  out  1  pipe drained after halt.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_n=0):
  - fwd_a = fwd_b = 00.
  - Every stall/flush/bubble output = 0, except freeze_all.
  - freeze_all = 0, halted = 0, err = 0.
  - FSM = RUN, drain counter = 0.
- Forward selects are registered.
  - They update on the edge where ID advances into EX: `!stall_if_id && !freeze_all`.
  - Source A, next value:
    - 01 if id_rs_vld & ex_regwrite & !ex_memread & id_rs==ex_wr.
    - else 10 if id_rs_vld & mem_regwrite & id_rs==mem_wr.
    - else 00.
  - EX match beats MEM match (youngest producer wins).
  - Source B uses the same rules with id_rt.
  - Selects are forced to 00 on bubble_ex or flush_id_ex.
  - The register file supplies the WB value via internal write-before-read; no WB-stage select exists.
- Load-use hazard (combinational):
  - Condition: id_vld & ex_memread & ex_regwrite & ((id_rs_vld & id_rs==ex_wr) | (id_rt_vld & id_rt==ex_wr)).
  - Response: stall_if_id = 1 and bubble_ex = 1 for exactly one cycle.
  - Next cycle the load is in MEM, the match re-evaluates to select 10, and the stall drops.
- Register 0 is an ordinary register: no zero-register exemption.
- Taken branch: br_taken=1 asserts flush_if_id, flush_id_ex and flush_ex_mem in the same cycle.
  - Flush overrides stall and bubble (both 0 that cycle).
- mem_busy=1:
  - freeze_all = 1; all other outputs hold their registered values.
  - Flushes are suppressed until mem_busy=0; br_taken is held by the MEM stage.
  - FSM and counter do not advance.
- FSM states: RUN, DRAIN, HALT.
  - RUN → DRAIN: on halt_ex & !br_taken & !mem_busy.
    - Same cycle: flush_if_id = flush_id_ex = 1, stall_if_id = 1; counter loads DRAIN_CYCLES.
    - halt_ex with br_taken is a squashed halt: stay in RUN.
  - DRAIN: stall_if_id = 1, flush_id_ex = 1; counter decrements each non-frozen cycle; → HALT when it reaches 0.
  - HALT: halted = 1, freeze_all = 1. Held until reset; the only exit is reset.
- err (sticky until reset):
  - set on br_taken in DRAIN or HALT;
  - set on halt_ex in DRAIN.
- Reset mid-DRAIN returns immediately to RUN with all outputs at their reset values.

Optional Feature:
- Macro: EX_HAZ_PERF_CNT_EN.
- When defined, adds outputs perf_stall_cnt[15:0] and perf_flush_cnt[15:0].
  - Saturating counts of load-use stall cycles and br_taken flush events.
  - Both clear on reset; neither counts while freeze_all=1.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package wisc_pipe_pkg holds:
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - FSM state encodings RUN/DRAIN/HALT;
  - REG_AW default.
- One natural sub-module, fwd_sel_unit: combinational match/priority for one source, instantiated twice (A and B).

Test Plan:
- add r3 in EX, ID reads r3 on rs: fwd_a becomes 01 the next cycle, no stall.
- ld r2 in EX, ID reads r2 on rt: one cycle stall_if_id=1 and bubble_ex=1, then fwd_b=10.
- EX and MEM both write r5, ID reads r5 on rs and rt: fwd_a=fwd_b=01.
- br_taken=1 during a load-use stall: all three flushes=1, stall_if_id=0.
- halt_ex=1 with DRAIN_CYCLES=2: halted=1 exactly 3 edges later; with mem_busy=1 for 4 of those cycles, 7 edges later. halt_ex together with br_taken: stays RUN, halted=0.
- rst_n low during DRAIN: FSM=RUN and all outputs 0 asynchronously. br_taken in HALT: err=1 and stays set.
